instr_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction memory: owns the program counter, drives the word address into instruction memory and presents each fetched instruction with its PC and a valid flag to decode.
- Compensates for the memory's 1-cycle registered read (address sampled at posedge, data valid the following cycle).
- Supports stall with a 1-entry hold buffer and branch redirect with squash.

---
 rtl/instr_fetch_unit.sv | 96 +++++++++
 tb/tb_instr_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, imem address and fetched-instruction presentation
//
// Purpose: owns the PC, drives the word address into a 1-cycle registered
// instruction memory and presents each fetched word to decode with its PC
// and a valid flag. A 1-entry hold buffer covers stalls, and a taken branch
// redirects the PC and squashes exactly one slot.
//
// Ports:
//   clk            system clock, all state on posedge
//   reset          synchronous, active-high
//   stall          downstream not consuming; hold current instr / instr_pc
//   branch_taken   redirect fetch to branch_target (overrides stall)
//   branch_target  word-index redirect target
//   imem_addr      word address to instruction memory (combinational from pc_q)
//   imem_data      memory read data for the address presented last cycle
//   instr          instruction to decode
//   instr_pc       word address of instr
//   instr_valid    instr / instr_pc are meaningful
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                  hold_valid_q, hold_valid_d;

    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        hold_d       = hold_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;

        if (branch_taken) begin
            // Whatever is in flight belongs to the wrong path: drop it.
            pc_d         = branch_target;
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            // The memory keeps re-reading pc_q, so the presented word would
            // be overwritten next cycle; park it in the hold buffer. A bubble
            // stays a bubble so nothing is presented twice after release.
            if (!hold_valid_q && resp_valid_q) begin
                hold_d       = imem_data;
                hold_pc_d    = resp_pc_q;
                hold_valid_d = 1'b1;
            end
        end else begin
            pc_d         = pc_q + ADDR_WIDTH'(1);
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
            hold_pc_q    <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            hold_q       <= hold_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Outputs depend only on flops and the registered memory data.
    assign imem_addr   = pc_q;
    assign instr       = hold_valid_q ? hold_q    : imem_data;
    assign instr_pc    = hold_valid_q ? hold_pc_q : resp_pc_q;
    assign instr_valid = hold_valid_q | resp_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    logic        reset2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        branch2 = 1'b0;
    logic [31:0] target2 = '0;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2 = '0;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic        instr_valid2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        chk_addr;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset2), .stall(stall2), .branch_taken(branch2),
        .branch_target(target2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2)
    );

    function automatic logic [31:0] im(input logic [31:0] a);
        case (a)
            32'd0:   im = 32'h0022_1820;
            32'd1:   im = 32'hAC01_0000;
            32'd2:   im = 32'h8C24_0000;
            32'd3:   im = 32'h1021_0001;
            default: im = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Registered-read instruction memories.
    always @(posedge clk) begin
        imem_data  <= im(imem_addr);
        imem_data2 <= im(imem_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic [31:0] pc);
        sb.push_back('{1'b1, im(pc), pc, 1'b0, 32'h0});
    endtask

    task automatic eva(input logic [31:0] pc, input logic [31:0] addr);
        sb.push_back('{1'b1, im(pc), pc, 1'b1, addr});
    endtask

    task automatic eb(input logic [31:0] addr);
        sb.push_back('{1'b0, 32'h0, 32'h0, 1'b1, addr});
    endtask

    // Compare the output presented this cycle, then drive the next inputs.
    task automatic cyc(input logic rs, input logic st, input logic br, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected>0");
        end else begin
            e = sb.pop_front();
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
            if (e.valid) begin
                chk("instr", instr, e.instr);
                chk("instr_pc", instr_pc, e.pc);
            end
            if (e.chk_addr) chk("imem_addr", imem_addr, e.addr);
        end
        reset = rs;
        stall = st;
        branch_taken = br;
        branch_target = tgt;
    endtask

    initial begin
        // Reset, fill bubble, free run
        eb(0);      cyc(1, 0, 0, 0);
        eb(0);      cyc(0, 0, 0, 0);
        ev(0);      cyc(0, 0, 0, 0);
        // Stall three cycles on (AC010000, 1)
        ev(1);      cyc(0, 1, 0, 0);
        eva(1, 2);  cyc(0, 1, 0, 0);
        eva(1, 2);  cyc(0, 1, 0, 0);
        eva(1, 2);  cyc(0, 0, 0, 0);
        ev(2);      cyc(0, 0, 0, 0);
        // Branch to 5 while instr_pc=3
        ev(3);      cyc(0, 0, 1, 5);
        eb(5);      cyc(0, 0, 0, 0);
        ev(5);      cyc(0, 0, 0, 0);
        ev(6);      cyc(0, 0, 0, 0);
        // Enter HELD, then branch+stall together
        ev(7);      cyc(0, 1, 0, 0);
        ev(7);      cyc(0, 1, 1, 20);
        eb(20);     cyc(0, 0, 0, 0);
        ev(20);     cyc(0, 0, 0, 0);
        // Reset during a 2-cycle stall
        ev(21);     cyc(0, 1, 0, 0);
        ev(21);     cyc(0, 1, 0, 0);
        ev(21);     cyc(1, 1, 0, 0);
        eb(0);      cyc(0, 0, 0, 0);
        ev(0);      cyc(0, 0, 0, 0);
        ev(1);      cyc(0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        // PC wrap with RESET_PC = FFFFFFFF
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        chk("wrap_reset_valid", {31'b0, instr_valid2}, 32'h0);
        chk("wrap_reset_addr", imem_addr2, 32'hFFFF_FFFF);
        reset2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] p;
            p = 32'hFFFF_FFFF + 32'(i);
            @(negedge clk);
            chk("wrap_valid", {31'b0, instr_valid2}, 32'h1);
            chk("wrap_pc", instr_pc2, p);
            chk("wrap_instr", instr2, im(p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
